serial_subtractor: RTL and testbench

Bit-serial N-bit subtractor built around the one-bit full-subtractor cell (X - Y - Z -> D, B). It captures two parallel operands and a borrow-in on a start request. It then feeds one bit pair per clock, LSB first, into the cell, registering the cell's borrow back into Z each cycle. Difference bits are collected in a shift register; a parallel result and a one-cycle done pulse are produced. It is the sequencing stage upstream of the full-subtractor cell, and it also consumes that cell's outputs.

---
 rtl/serial_subtractor_if.sv | 23 ++
 rtl/serial_subtractor.sv | 105 ++++++++++
 tb/tb_serial_subtractor.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle between a requester and the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor step per clock, LSB first,
// with the borrow fed back through a flop and a parallel result plus done pulse.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus_if
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] diff_sh_q, diff_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             z_q, z_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic cell_x, cell_y, cell_d, cell_bn;

  // Full-subtractor cell: x - y - z
  always_comb begin
    cell_x  = a_sh_q[0];
    cell_y  = b_sh_q[0];
    cell_d  = cell_x ^ cell_y ^ z_q;
    cell_bn = (~cell_x & cell_y) | (~cell_x & z_q) | (cell_y & z_q);
  end

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    diff_sh_d = diff_sh_q;
    diff_d    = diff_q;
    bout_d    = bout_q;
    z_d       = z_q;
    cnt_d     = cnt_q;
    case (state_q)
      // The DONE exit edge doubles as an accept edge, so a held start
      // yields operations spaced WIDTH+1 cycles apart.
      StIdle, StDone: begin
        state_d = StIdle;
        if (bus_if.start) begin
          state_d   = StShift;
          a_sh_d    = bus_if.a;
          b_sh_d    = bus_if.b;
          z_d       = bus_if.bin;
          cnt_d     = '0;
          diff_sh_d = '0;
        end
      end
      StShift: begin
        a_sh_d    = a_sh_q >> 1;
        b_sh_d    = b_sh_q >> 1;
        diff_sh_d = {cell_d, diff_sh_q[WIDTH-1:1]};
        z_d       = cell_bn;
        cnt_d     = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = StDone;
          diff_d  = {cell_d, diff_sh_q[WIDTH-1:1]};
          bout_d  = cell_bn;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      diff_sh_q <= '0;
      diff_q    <= '0;
      bout_q    <= 1'b0;
      z_q       <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      diff_sh_q <= diff_sh_d;
      diff_q    <= diff_d;
      bout_q    <= bout_d;
      z_q       <= z_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    bus_if.busy = (state_q != StIdle);
    bus_if.done = (state_q == StDone);
    bus_if.diff = diff_q;
    bus_if.bout = bout_q;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor against an arithmetic model.
module tb_serial_subtractor;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] held_diff = '0;
  logic         held_bout = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // (a - b - bin) as a WIDTH+1 bit two's-complement value; top bit is the borrow.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic bin);
    return {1'b0, a} - {1'b0, b} - (W+1)'(bin);
  endfunction

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       input bit stray);
    logic [W:0] exp;
    int c;
    int busy_n;
    bit quiet;
    exp = model(a, b, bin);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.bin   = 1'($urandom);
    chk("diff_hold", 32'(bus.diff), 32'(held_diff));
    chk("bout_hold", 32'(bus.bout), 32'(held_bout));
    c = 0;
    busy_n = 0;
    while (!bus.done && c < 40) begin
      if (bus.busy) busy_n++;
      if (stray) bus.start = (c == 2 || c == 5);
      @(negedge clk);
      c++;
    end
    bus.start = 1'b0;
    if (bus.busy) busy_n++;
    chk("latency", 32'(c), 32'(W));
    chk("diff", 32'(bus.diff), 32'(exp[W-1:0]));
    chk("bout", 32'(bus.bout), 32'(exp[W]));
    held_diff = exp[W-1:0];
    held_bout = exp[W];
    @(negedge clk);
    chk("done_pulse_width", 32'(bus.done), 32'd0);
    chk("busy_cycles", 32'(busy_n), 32'(W + 1));
    if (stray) begin
      quiet = 1'b1;
      repeat (W + 3) begin
        if (bus.busy || bus.done) quiet = 1'b0;
        @(negedge clk);
      end
      chk("stray_start_ignored", 32'(quiet), 32'd1);
    end
  endtask

  initial begin
    int t1;
    int t2;
    int c;
    bit quiet;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    #12;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_diff", 32'(bus.diff), 32'd0);
    chk("rst_bout", 32'(bus.bout), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op(8'h55, 8'h22, 1'b0, 1'b0);
    do_op(8'h00, 8'h01, 1'b0, 1'b0);
    do_op(8'h00, 8'h00, 1'b1, 1'b0);
    do_op(8'h80, 8'h7F, 1'b1, 1'b1);

    // Cell truth table via LSBs and borrow-in
    for (int i = 0; i < 8; i++) begin
      ra = {W'($urandom) >> 1, 1'(i)} ;
      rb = {W'($urandom) >> 1, 1'(i >> 1)};
      do_op({ra[W-2:0], 1'(i)}, {rb[W-2:0], 1'(i >> 1)}, 1'(i >> 2), 1'b0);
    end

    // Back-to-back with start held high
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h10;
    bus.b     = 8'h01;
    bus.bin   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.a = 8'h01;
    bus.b = 8'h10;
    c = 0;
    while (!bus.done && c < 40) begin @(negedge clk); c++; end
    t1 = cyc;
    chk("b2b_first_diff", 32'(bus.diff), 32'h0F);
    chk("b2b_first_bout", 32'(bus.bout), 32'd0);
    @(negedge clk);
    c = 0;
    while (!bus.done && c < 40) begin @(negedge clk); c++; end
    t2 = cyc;
    bus.start = 1'b0;
    chk("b2b_second_diff", 32'(bus.diff), 32'hF1);
    chk("b2b_second_bout", 32'(bus.bout), 32'd1);
    chk("b2b_spacing", 32'(t2 - t1), 32'(W + 1));
    held_diff = 8'hF1;
    held_bout = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("b2b_idle", 32'(bus.busy), 32'd0);

    // Asynchronous reset in the middle of an operation
    bus.start = 1'b1;
    bus.a     = 8'hC3;
    bus.b     = 8'h5A;
    bus.bin   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_diff", 32'(bus.diff), 32'd0);
    chk("abort_bout", 32'(bus.bout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    repeat (W + 3) begin
      if (bus.busy || bus.done) quiet = 1'b0;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(quiet), 32'd1);
    held_diff = '0;
    held_bout = 1'b0;
    do_op(8'h09, 8'h03, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
